// File: rtl/zwait_pkg.sv
// zwait_pkg: shared constants and state encoding for the Z80 wait arbiter
package zwait_pkg;
    localparam int NSRC      = 4;
    localparam int SRC_W     = 2;
    localparam int TMO_W_DEF = 12;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
endpackage

// File: rtl/zwait_rr.sv
// zwait_rr: combinational 4-way round-robin pick starting after the last grant
module zwait_rr
    import zwait_pkg::*;
(
    input  logic [NSRC-1:0]  req,
    input  logic [SRC_W-1:0] last,
    output logic [SRC_W-1:0] gnt_id,
    output logic             gnt_vld
);
    logic [SRC_W-1:0] w_idx;
    // scan from the farthest candidate back to last+1 so the nearest requester wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = last;
        w_idx   = last;
        for (int k = NSRC; k >= 1; k--) begin
            w_idx = last + SRC_W'(k);
            if (req[w_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = w_idx;
            end
        end
    end
endmodule

// File: rtl/zwait_arb.sv
// zwait_arb: holds the Z80 in WAIT while the AVR services queued I/O accesses
module zwait_arb
    import zwait_pkg::*;
#(
    parameter int TMO_W   = TMO_W_DEF,
    parameter int REL_CYC = 2
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic [NSRC-1:0]   wait_start,
    input  logic              wait_rnw_in,
    input  logic [7:0]        wait_wdata_in,
    output logic              wait_n,
    output logic [7:0]        wait_read,
    output logic              avr_req,
    output logic [SRC_W-1:0]  avr_src,
    output logic              avr_rnw,
    output logic [7:0]        avr_wdata,
    input  logic              avr_ack,
    input  logic [7:0]        avr_rdata,
    output logic [NSRC-1:0]   pending,
    output logic              timeout
);
    localparam int REL_W = $clog2(REL_CYC + 1);

    logic [1:0]       r_state;
    logic             r_wait_n;
    logic             r_req;
    logic [SRC_W-1:0] r_src;
    logic             r_rnw;
    logic [7:0]       r_wdata;
    logic [7:0]       r_read;
    logic [NSRC-1:0]  r_pend;
    logic             r_tmo;
    logic [TMO_W-1:0] r_cnt;
    logic [REL_W-1:0] r_rel;
    logic [SRC_W-1:0] r_last;
    logic             r_cap_rnw [NSRC];
    logic [7:0]       r_cap_wd  [NSRC];

    logic [NSRC-1:0]  w_req;
    logic [NSRC-1:0]  w_clr;
    logic [SRC_W-1:0] w_gid;
    logic             w_gvld;
    logic             w_ack;
    logic             w_tmo;
    logic             w_done;

    assign w_req  = r_pend | wait_start;
    assign w_ack  = (r_state == ST_SERVE) && avr_ack;
    assign w_tmo  = (r_state == ST_SERVE) && !avr_ack && (r_cnt == '1);
    assign w_done = w_ack | w_tmo;
    assign w_clr  = w_done ? (NSRC'(1) << r_src) : '0;

    zwait_rr u_rr (
        .req     (w_req),
        .last    (r_last),
        .gnt_id  (w_gid),
        .gnt_vld (w_gvld)
    );

    // capture starts, run the IDLE/SERVE/RELEASE sequence and drive the AVR channel
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wait_n <= 1'b1;
            r_req    <= 1'b0;
            r_src    <= '0;
            r_rnw    <= 1'b1;
            r_wdata  <= '0;
            r_read   <= 8'hFF;
            r_pend   <= '0;
            r_tmo    <= 1'b0;
            r_cnt    <= '0;
            r_rel    <= '0;
            r_last   <= '0;
            for (int k = 0; k < NSRC; k++) begin
                r_cap_rnw[k] <= 1'b0;
                r_cap_wd[k]  <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~w_clr) | wait_start;
            r_tmo  <= w_tmo;
            for (int k = 0; k < NSRC; k++) begin
                if (wait_start[k]) begin
                    r_cap_rnw[k] <= wait_rnw_in;
                    r_cap_wd[k]  <= wait_wdata_in;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_gvld) begin
                        r_state  <= ST_SERVE;
                        r_wait_n <= 1'b0;
                        r_req    <= 1'b1;
                        r_src    <= w_gid;
                        r_rnw    <= wait_start[w_gid] ? wait_rnw_in : r_cap_rnw[w_gid];
                        r_wdata  <= wait_start[w_gid] ? wait_wdata_in : r_cap_wd[w_gid];
                        r_cnt    <= '0;
                    end
                end
                ST_SERVE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_state  <= ST_RELEASE;
                        r_wait_n <= 1'b1;
                        r_req    <= 1'b0;
                        r_rel    <= '0;
                        if (r_rnw) r_read <= w_ack ? avr_rdata : 8'hFF;
                        if (w_ack) r_last <= r_src;
                    end
                end
                ST_RELEASE: begin
                    if (r_rel == REL_W'(REL_CYC - 1)) r_state <= ST_IDLE;
                    else r_rel <= r_rel + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wait_n    = r_wait_n;
    assign wait_read = r_read;
    assign avr_req   = r_req;
    assign avr_src   = r_src;
    assign avr_rnw   = r_rnw;
    assign avr_wdata = r_wdata;
    assign pending   = r_pend;
    assign timeout   = r_tmo;
endmodule

// File: tb/tb_zwait_arb.sv
// tb_zwait_arb: directed and random checks of zwait_arb against a cycle model
module tb_zwait_arb;
    localparam int TMO = 4;
    localparam int REL = 2;

    logic       fclk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wait_start = '0;
    logic       wait_rnw_in = 1'b0;
    logic [7:0] wait_wdata_in = '0;
    logic       wait_n;
    logic [7:0] wait_read;
    logic       avr_req;
    logic [1:0] avr_src;
    logic       avr_rnw;
    logic [7:0] avr_wdata;
    logic       avr_ack = 1'b0;
    logic [7:0] avr_rdata = '0;
    logic [3:0] pending;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    zwait_arb #(.TMO_W(TMO), .REL_CYC(REL)) dut (
        .fclk          (fclk),
        .rst           (rst),
        .wait_start    (wait_start),
        .wait_rnw_in   (wait_rnw_in),
        .wait_wdata_in (wait_wdata_in),
        .wait_n        (wait_n),
        .wait_read     (wait_read),
        .avr_req       (avr_req),
        .avr_src       (avr_src),
        .avr_rnw       (avr_rnw),
        .avr_wdata     (avr_wdata),
        .avr_ack       (avr_ack),
        .avr_rdata     (avr_rdata),
        .pending       (pending),
        .timeout       (timeout)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: an access is either being served (with elapsed cycles),
    // in a release gap, or the arbiter is free to pick the next requester
    bit         m_init = 0;
    bit         m_srv;
    int         m_ela;
    int         m_gap;
    logic [1:0] m_src;
    logic [1:0] m_last;
    logic       m_rnw;
    logic [7:0] m_wd;
    logic [7:0] m_read;
    logic [3:0] m_pend;
    logic       m_tmo;
    logic       m_slot_rnw [4];
    logic [7:0] m_slot_wd [4];

    always @(posedge fclk) begin : model
        logic [3:0] req;
        int w;
        bit found;
        if (rst) begin
            m_srv = 0; m_ela = 0; m_gap = 0; m_src = 0; m_last = 0; m_rnw = 1;
            m_wd = 0; m_read = 8'hFF; m_pend = 0; m_tmo = 0;
            for (int k = 0; k < 4; k++) begin
                m_slot_rnw[k] = 0;
                m_slot_wd[k] = 0;
            end
            m_init = 1;
        end else begin
            m_tmo = 0;
            if (m_srv) begin
                if (avr_ack || m_ela == (1 << TMO) - 1) begin
                    if (m_rnw) m_read = avr_ack ? avr_rdata : 8'hFF;
                    if (avr_ack) m_last = m_src;
                    else m_tmo = 1;
                    m_srv = 0;
                    m_gap = REL;
                    m_pend[m_src] = 1'b0;
                end else m_ela++;
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                req = m_pend | wait_start;
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    w = (int'(m_last) + k) % 4;
                    if (!found && req[w]) begin
                        found = 1;
                        m_srv = 1;
                        m_ela = 0;
                        m_src = 2'(w);
                        m_rnw = wait_start[w] ? wait_rnw_in : m_slot_rnw[w];
                        m_wd  = wait_start[w] ? wait_wdata_in : m_slot_wd[w];
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (wait_start[k]) begin
                    m_pend[k] = 1'b1;
                    m_slot_rnw[k] = wait_rnw_in;
                    m_slot_wd[k] = wait_wdata_in;
                end
            end
        end
    end

    // compare every DUT output with the model mid-cycle
    always @(negedge fclk) begin
        if (m_init) begin
            check("wait_n", 32'(wait_n), 32'(!m_srv));
            check("avr_req", 32'(avr_req), 32'(m_srv));
            check("avr_src", 32'(avr_src), 32'(m_src));
            check("avr_rnw", 32'(avr_rnw), 32'(m_rnw));
            check("avr_wdata", 32'(avr_wdata), 32'(m_wd));
            check("wait_read", 32'(wait_read), 32'(m_read));
            check("pending", 32'(pending), 32'(m_pend));
            check("timeout", 32'(timeout), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m, input logic r, input logic [7:0] d);
        wait_start = m;
        wait_rnw_in = r;
        wait_wdata_in = d;
        tick();
        wait_start = '0;
    endtask

    task automatic ack_pulse(input logic [7:0] d);
        avr_ack = 1'b1;
        avr_rdata = d;
        tick();
        avr_ack = 1'b0;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!avr_req && n < 10) begin
            tick();
            n++;
        end
        check("req_wait_bound", 32'(avr_req), 32'd1);
    endtask

    initial begin : drive
        logic [1:0] exp_src [3];
        logic [3:0] exp_pend [3];
        int n;
        exp_src = '{2'd1, 2'd3, 2'd0};
        exp_pend = '{4'b1011, 4'b1001, 4'b0001};
        repeat (3) tick();
        rst = 1'b0;
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_wait_read", 32'(wait_read), 32'hFF);
        check("rst_avr_rnw", 32'(avr_rnw), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        tick();

        pulse(4'b0100, 1'b0, 8'h33);
        check("wr_wait_n", 32'(wait_n), 32'd0);
        check("wr_src", 32'(avr_src), 32'd2);
        check("wr_rnw", 32'(avr_rnw), 32'd0);
        check("wr_wdata", 32'(avr_wdata), 32'h33);
        repeat (2) tick();
        ack_pulse(8'h00);
        check("wr_read_kept", 32'(wait_read), 32'hFF);
        check("wr_wait_n_rel", 32'(wait_n), 32'd1);
        settle();

        pulse(4'b0001, 1'b1, 8'h00);
        check("rd_wait_n", 32'(wait_n), 32'd0);
        check("rd_src", 32'(avr_src), 32'd0);
        repeat (9) tick();
        ack_pulse(8'h5A);
        check("rd_wait_n_rel", 32'(wait_n), 32'd1);
        check("rd_data", 32'(wait_read), 32'h5A);
        check("rd_pending", 32'(pending), 32'd0);
        tick();
        check("rd_wait_n_rel2", 32'(wait_n), 32'd1);
        settle();

        pulse(4'b1011, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_req();
            check("rr_src", 32'(avr_src), 32'(exp_src[i]));
            check("rr_pending", 32'(pending), 32'(exp_pend[i]));
            tick();
            ack_pulse(8'h10 + 8'(i));
        end
        check("rr_pending_end", 32'(pending), 32'd0);
        check("rr_last_data", 32'(wait_read), 32'h12);
        settle();

        pulse(4'b0010, 1'b1, 8'h00);
        n = 0;
        while (!timeout && n < 40) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        check("tmo_read", 32'(wait_read), 32'hFF);
        check("tmo_wait_n", 32'(wait_n), 32'd1);
        tick();
        check("tmo_one_pulse", 32'(timeout), 32'd0);
        settle();

        pulse(4'b0001, 1'b1, 8'h00);
        repeat (15) tick();
        ack_pulse(8'hC3);
        check("edge_timeout", 32'(timeout), 32'd0);
        check("edge_data", 32'(wait_read), 32'hC3);
        tick();
        check("edge_timeout2", 32'(timeout), 32'd0);
        settle();

        pulse(4'b1000, 1'b1, 8'h00);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_wait_n", 32'(wait_n), 32'd1);
        check("mid_rst_req", 32'(avr_req), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        ack_pulse(8'h77);
        check("late_ack_read", 32'(wait_read), 32'hFF);
        check("late_ack_req", 32'(avr_req), 32'd0);
        tick();

        for (int c = 0; c < 1500; c++) begin
            wait_start = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            wait_rnw_in = 1'($urandom);
            wait_wdata_in = 8'($urandom);
            avr_rdata = 8'($urandom);
            avr_ack = avr_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        wait_start = '0;
        avr_ack = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
